// File: rtl/ps2_keymap_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keymap_decoder
//
// Turns the byte stream coming out of PS2_Controller into per-key state for
// game logic. Each of NUM_KEYS mapped keys gets a held level plus one-cycle
// make and break pulses. A key may be a plain scan code or an E0-extended
// one. The E1 Pause sequence is swallowed, and typematic repeats of a key
// that is already held are ignored.
//
// Parameters
//   NUM_KEYS        number of mapped keys (1..16)
//   KEY_CODES       NUM_KEYS x 9-bit map; entry i = bits [9i+8:9i],
//                   bit 8 = E0-extended flag, bits 7:0 = scan code
//   TIMEOUT_CYCLES  prefix timeout in clocks (optional feature only)
//
// Ports
//   CLOCK_50         in   system clock
//   Resetn           in   asynchronous active-low reset
//   ps2_key_data     in   received byte, valid while ps2_key_pressed=1
//   ps2_key_pressed  in   one-cycle byte-valid strobe
//   held_clear       in   synchronous clear of all held bits, no break pulses
//   key_held         out  bit i high while key i is down
//   key_make         out  one-cycle pulse on a new press of key i
//   key_break        out  one-cycle pulse on release of key i
//   any_held         out  registered OR of key_held (one cycle behind)
//   unmapped         out  one-cycle pulse when a complete code maps to no key
//
// Optional feature (macro PS2_KEYMAP_PREFIX_TIMEOUT_EN):
//   When defined, a partially received prefix (E0/F0/Pause) that sits idle
//   for TIMEOUT_CYCLES clocks is abandoned and the decoder returns to IDLE.
//   When undefined, prefix states wait indefinitely for the next byte.
// ---------------------------------------------------------------------------
module ps2_keymap_decoder #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h029, 9'h174, 9'h16B, 9'h175},
    parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                CLOCK_50,
    input  logic                Resetn,
    input  logic [7:0]          ps2_key_data,
    input  logic                ps2_key_pressed,
    input  logic                held_clear,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_make,
    output logic [NUM_KEYS-1:0] key_break,
    output logic                any_held,
    output logic                unmapped
);

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    // The Pause make code is E1 followed by seven more bytes.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_e;

    // A mis-sized key map or a degenerate timeout is a build error rather
    // than a silently broken decoder.
    generate
        if (NUM_KEYS < 1 || NUM_KEYS > 16 || TIMEOUT_CYCLES < 2) begin : gParamCheck
            $error("ps2_keymap_decoder: NUM_KEYS or TIMEOUT_CYCLES out of range");
        end
    endgenerate

    state_e              state_q;
    logic [2:0]          skipCount_q;
    logic [NUM_KEYS-1:0] keyHeld_q;
    logic [NUM_KEYS-1:0] keyMake_q;
    logic [NUM_KEYS-1:0] keyBreak_q;
    logic                anyHeld_q;
    logic                unmapped_q;

    logic                termValid_d;
    logic                termExt_d;
    logic                termBrk_d;
    logic [NUM_KEYS-1:0] matchVec_d;
    logic [NUM_KEYS-1:0] keyHeld_d;
    logic [NUM_KEYS-1:0] keyMake_d;
    logic [NUM_KEYS-1:0] keyBreak_d;
    logic                unmapped_d;

`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
    localparam int                   TIMEOUT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] timeoutCount_q;
`endif

    // Work out whether the byte on the bus this cycle finishes a make/break
    // code, which keys it names, and what the key outputs should become.
    // The ext/brk flags come straight from the prefix state we are leaving.
    // A same-cycle held_clear wins over everything, so a make arriving with
    // it neither latches the key nor pulses.
    always_comb begin
        termExt_d   = (state_q == EXT) || (state_q == EXT_BRK);
        termBrk_d   = (state_q == BRK) || (state_q == EXT_BRK);
        termValid_d = ps2_key_pressed && (state_q != SKIP) &&
                      (ps2_key_data != BYTE_E0) && (ps2_key_data != BYTE_E1) &&
                      (ps2_key_data != BYTE_F0);

        matchVec_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            matchVec_d[i] = (KEY_CODES[9*i +: 9] == {termExt_d, ps2_key_data});
        end

        keyHeld_d  = keyHeld_q;
        keyMake_d  = '0;
        keyBreak_d = '0;
        unmapped_d = termValid_d && (matchVec_d == '0);

        if (termValid_d) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (matchVec_d[i]) begin
                    if (!termBrk_d && !keyHeld_q[i]) begin
                        keyHeld_d[i] = 1'b1;
                        keyMake_d[i] = 1'b1;
                    end else if (termBrk_d && keyHeld_q[i]) begin
                        keyHeld_d[i]  = 1'b0;
                        keyBreak_d[i] = 1'b1;
                    end
                end
            end
        end

        if (held_clear) begin
            keyHeld_d  = '0;
            keyMake_d  = '0;
            keyBreak_d = '0;
        end
    end

    // Prefix tracking state machine. Only strobed bytes move it. While in
    // SKIP every byte is thrown away, including E0/E1/F0, until the Pause
    // tail has been counted out. With the timeout feature enabled, an idle
    // prefix state counts clocks and gives up once the limit is reached.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            skipCount_q <= '0;
`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
            timeoutCount_q <= '0;
`endif
        end else begin
            if (ps2_key_pressed) begin
`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
                timeoutCount_q <= '0;
`endif
                if (state_q == SKIP) begin
                    skipCount_q <= skipCount_q - 3'd1;
                    if (skipCount_q <= 3'd1) begin
                        state_q <= IDLE;
                    end
                end else if (ps2_key_data == BYTE_E1) begin
                    state_q     <= SKIP;
                    skipCount_q <= PAUSE_TAIL;
                end else if (ps2_key_data == BYTE_E0) begin
                    state_q <= EXT;
                end else if (ps2_key_data == BYTE_F0) begin
                    if (state_q == IDLE) begin
                        state_q <= BRK;
                    end else if (state_q == EXT) begin
                        state_q <= EXT_BRK;
                    end
                end else begin
                    state_q <= IDLE;
                end
            end
`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
            else if (state_q != IDLE) begin
                if (timeoutCount_q == TIMEOUT_LAST) begin
                    state_q        <= IDLE;
                    skipCount_q    <= '0;
                    timeoutCount_q <= '0;
                end else begin
                    timeoutCount_q <= timeoutCount_q + 1'b1;
                end
            end else begin
                timeoutCount_q <= '0;
            end
`endif
        end
    end

    // Key outputs are registered so game logic sees clean, glitch-free
    // levels and pulses one clock after the final byte's strobe. any_held
    // is taken from the registered held bits and therefore trails by one.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            keyHeld_q  <= '0;
            keyMake_q  <= '0;
            keyBreak_q <= '0;
            anyHeld_q  <= 1'b0;
            unmapped_q <= 1'b0;
        end else begin
            keyHeld_q  <= keyHeld_d;
            keyMake_q  <= keyMake_d;
            keyBreak_q <= keyBreak_d;
            anyHeld_q  <= |keyHeld_q;
            unmapped_q <= unmapped_d;
        end
    end

    assign key_held  = keyHeld_q;
    assign key_make  = keyMake_q;
    assign key_break = keyBreak_q;
    assign any_held  = anyHeld_q;
    assign unmapped  = unmapped_q;

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_keymap_decoder
//
// Drives ps2_keymap_decoder with directed byte sequences followed by a long
// random byte stream. Expected outputs come from a behavioural model that
// keeps the pending prefix bytes in a queue and looks keys up in its own
// table of the default key map.
// ---------------------------------------------------------------------------
module tb_ps2_keymap_decoder;

    localparam int TB_TIMEOUT = 100;

    logic       CLOCK_50;
    logic       Resetn;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       held_clear;
    logic [3:0] key_held;
    logic [3:0] key_make;
    logic [3:0] key_break;
    logic       any_held;
    logic       unmapped;

    int total;
    int bad;

    logic [8:0] keyTable [4] = '{9'h175, 9'h16B, 9'h174, 9'h029};
    logic [7:0] bytePool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h6B, 8'h74,
                                  8'h29, 8'h14, 8'h77, 8'h1C, 8'h5A, 8'hF0};

    logic [3:0] modelHeld;
    logic [7:0] prefixQ [$];
    int         skipLeft;
    int         gap;

    logic [3:0] expHeld;
    logic [3:0] expMake;
    logic [3:0] expBreak;
    logic       expAny;
    logic       expUnm;

    ps2_keymap_decoder #(
        .NUM_KEYS       (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .Resetn          (Resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .held_clear      (held_clear),
        .key_held        (key_held),
        .key_make        (key_make),
        .key_break       (key_break),
        .any_held        (any_held),
        .unmapped        (unmapped)
    );

    // Free-running 100 MHz-style clock; the period is arbitrary here.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("key_held", {12'b0, key_held}, {12'b0, expHeld});
        checkOutput("key_make", {12'b0, key_make}, {12'b0, expMake});
        checkOutput("key_break", {12'b0, key_break}, {12'b0, expBreak});
        checkOutput("any_held", {15'b0, any_held}, {15'b0, expAny});
        checkOutput("unmapped", {15'b0, unmapped}, {15'b0, expUnm});
    endtask

    // Reference model: bytes before the terminating code are remembered in
    // a queue; an E0 discards what came before it, E1 arms a 7-byte skip.
    task automatic modelStep(input logic strobe, input logic [7:0] data, input logic clear);
        logic       ext;
        logic       brk;
        logic       hit;
        logic [8:0] code;
        expAny   = |modelHeld;
        expMake  = '0;
        expBreak = '0;
        expUnm   = 1'b0;
        if (strobe) begin
            gap = 0;
            if (skipLeft > 0) begin
                skipLeft--;
            end else if (data == 8'hE1) begin
                skipLeft = 7;
                prefixQ.delete();
            end else if (data == 8'hE0) begin
                prefixQ.delete();
                prefixQ.push_back(data);
            end else if (data == 8'hF0) begin
                prefixQ.push_back(data);
            end else begin
                ext = (prefixQ.size() > 0) && (prefixQ[0] == 8'hE0);
                brk = 1'b0;
                foreach (prefixQ[k]) begin
                    if (prefixQ[k] == 8'hF0) brk = 1'b1;
                end
                prefixQ.delete();
                code = {ext, data};
                hit  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (keyTable[i] == code) begin
                        hit = 1'b1;
                        if (!brk && !modelHeld[i]) begin
                            modelHeld[i] = 1'b1;
                            expMake[i]   = 1'b1;
                        end else if (brk && modelHeld[i]) begin
                            modelHeld[i] = 1'b0;
                            expBreak[i]  = 1'b1;
                        end
                    end
                end
                expUnm = !hit;
            end
        end else if (skipLeft > 0 || prefixQ.size() > 0) begin
            gap++;
`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
            if (gap >= TB_TIMEOUT) begin
                prefixQ.delete();
                skipLeft = 0;
                gap      = 0;
            end
`endif
        end
        if (clear) begin
            modelHeld = '0;
            expMake   = '0;
            expBreak  = '0;
        end
        expHeld = modelHeld;
    endtask

    // One clock of stimulus: check what the previous cycle produced, then
    // drive the new inputs and let the model predict the next outputs.
    task automatic applyStimulus(input logic strobe, input logic [7:0] data, input logic clear);
        @(negedge CLOCK_50);
        compareAll();
        ps2_key_pressed = strobe;
        ps2_key_data    = data;
        held_clear      = clear;
        modelStep(strobe, data, clear);
    endtask

    task automatic sendByte(input logic [7:0] data);
        applyStimulus(1'b1, data, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge CLOCK_50);
        compareAll();
        Resetn          = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        held_clear      = 1'b0;
        #2;
        checkOutput("rst_held", {12'b0, key_held}, 16'h0);
        checkOutput("rst_make", {12'b0, key_make}, 16'h0);
        checkOutput("rst_break", {12'b0, key_break}, 16'h0);
        checkOutput("rst_any", {15'b0, any_held}, 16'h0);
        checkOutput("rst_unmapped", {15'b0, unmapped}, 16'h0);
        modelHeld = '0;
        prefixQ.delete();
        skipLeft = 0;
        gap      = 0;
        expHeld  = '0;
        expMake  = '0;
        expBreak = '0;
        expAny   = 1'b0;
        expUnm   = 1'b0;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        total           = 0;
        bad             = 0;
        Resetn          = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        held_clear      = 1'b0;
        modelHeld       = '0;
        skipLeft        = 0;
        gap             = 0;
        expHeld         = '0;
        expMake         = '0;
        expBreak        = '0;
        expAny          = 1'b0;
        expUnm          = 1'b0;
        #1;
        applyReset();

        // Up make then break.
        sendByte(8'hE0);
        sendByte(8'h75);
        idleCycles(1);
        checkOutput("up_held", {12'b0, key_held}, 16'h0001);
        checkOutput("up_make", {12'b0, key_make}, 16'h0001);
        idleCycles(1);
        checkOutput("up_make_width", {12'b0, key_make}, 16'h0000);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        idleCycles(1);
        checkOutput("up_released", {12'b0, key_held}, 16'h0000);
        checkOutput("up_break", {12'b0, key_break}, 16'h0001);

        // Space typematic repeat, back-to-back strobes.
        sendByte(8'h29);
        sendByte(8'h29);
        checkOutput("space_make_first", {12'b0, key_make}, 16'h0008);
        sendByte(8'h29);
        checkOutput("space_no_repeat", {12'b0, key_make}, 16'h0000);
        idleCycles(1);
        checkOutput("space_held", {12'b0, key_held}, 16'h0008);
        sendByte(8'hF0);
        sendByte(8'h29);
        idleCycles(1);
        checkOutput("space_released", {12'b0, key_held}, 16'h0000);

        // Plain 6B is not the extended Left key.
        sendByte(8'h6B);
        idleCycles(1);
        checkOutput("plain_6b_unmapped", {15'b0, unmapped}, 16'h0001);
        checkOutput("plain_6b_held", {12'b0, key_held}, 16'h0000);
        applyStimulus(1'b0, 8'h75, 1'b0);
        applyStimulus(1'b0, 8'hE0, 1'b0);

        // Pause sequence is swallowed, then Right.
        sendByte(8'hE1);
        sendByte(8'h14);
        sendByte(8'h77);
        sendByte(8'hE1);
        sendByte(8'hF0);
        sendByte(8'h14);
        sendByte(8'hF0);
        sendByte(8'h77);
        sendByte(8'hE0);
        sendByte(8'h74);
        idleCycles(1);
        checkOutput("right_after_pause", {12'b0, key_held}, 16'h0004);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h74);

        // Up + Left held, then cleared without break pulses.
        sendByte(8'hE0);
        sendByte(8'h75);
        sendByte(8'hE0);
        sendByte(8'h6B);
        idleCycles(2);
        checkOutput("two_held", {12'b0, key_held}, 16'h0003);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idleCycles(1);
        checkOutput("clear_held", {12'b0, key_held}, 16'h0000);
        checkOutput("clear_no_break", {12'b0, key_break}, 16'h0000);
        checkOutput("clear_any_lags", {15'b0, any_held}, 16'h0001);
        idleCycles(1);
        checkOutput("clear_any_falls", {15'b0, any_held}, 16'h0000);

        // Reset between E0 and 75 drops the prefix.
        sendByte(8'hE0);
        applyReset();
        sendByte(8'h75);
        idleCycles(1);
        checkOutput("reset_mid_unmapped", {15'b0, unmapped}, 16'h0001);
        checkOutput("reset_mid_held", {12'b0, key_held}, 16'h0000);

`ifdef PS2_KEYMAP_PREFIX_TIMEOUT_EN
        sendByte(8'hE0);
        idleCycles(150);
        sendByte(8'h75);
        idleCycles(1);
        checkOutput("timeout_unmapped", {15'b0, unmapped}, 16'h0001);
        checkOutput("timeout_no_make", {12'b0, key_make}, 16'h0000);
        sendByte(8'hE0);
        idleCycles(50);
        sendByte(8'h75);
        idleCycles(1);
        checkOutput("no_timeout_make", {12'b0, key_make}, 16'h0001);
`endif

        // Random byte stream against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                applyReset();
            end else begin
                if ($urandom_range(0, 9) == 0) rb = 8'($urandom_range(0, 255));
                else rb = bytePool[$urandom_range(0, 11)];
                applyStimulus($urandom_range(0, 99) < 55, rb, $urandom_range(0, 99) < 2);
            end
        end
        idleCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
